// File: rtl/cga_wrf_pkg.sv
// Shared types and sizes for the working-register-file write scheduler.
// Imported by the per-port queue and the scheduler top.
package cga_wrf_pkg;

   localparam int NREG   = 16;
   localparam int DW     = 16;
   localparam int AW     = 4;
   localparam int QDEPTH = 2;

   typedef enum logic [1:0] {
      PORT_ALU,
      PORT_LD,
      PORT_SC,
      PORT_NONE
   } portSelT;

   typedef struct packed {
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
   } wrEntryT;

   function automatic logic [NREG-1:0] oneHot(input logic [AW-1:0] wa);
      oneHot     = '0;
      oneHot[wa] = 1'b1;
   endfunction

endpackage

// File: rtl/cga_wrf_wq2.sv
// Small FIFO of pending register writes for one buffered port.
// A push while full is dropped; the requester sees that through full.
module cga_wrf_wq2
   import cga_wrf_pkg::*;
#(
   parameter int DEPTH = QDEPTH
)
(
   input  logic    clk,
   input  logic    rstN,
   input  logic    push,
   input  wrEntryT pushData,
   input  logic    pop,
   output wrEntryT head,
   output logic    full,
   output logic    empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   wrEntryT       mem [DEPTH];
   logic [PW-1:0] rdPtr;
   logic [PW-1:0] wrPtr;
   logic [CW-1:0] count;
   logic          doPush;
   logic          doPop;

   assign full   = (count == CW'(DEPTH));
   assign empty  = (count == '0);
   assign doPush = push && !full;
   assign doPop  = pop && !empty;
   assign head   = mem[rdPtr];

   function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= nextPtr(wrPtr);
         if (doPop)  rdPtr <= nextPtr(rdPtr);
         count <= count + CW'(doPush) - CW'(doPop);
      end
   end

   // Storage needs no reset: count gates every read that matters.
   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= pushData;
   end

endmodule

// File: rtl/cga_wrf_write_sched.sv
// Shares the register-file write bus between ALU writeback (absolute priority)
// and the buffered load and scan ports, which alternate round-robin.
module cga_wrf_write_sched
   import cga_wrf_pkg::*;
(
   input  logic            ALUCLK,
   input  logic            RESET_N,
   input  logic            ALU_WE,
   input  logic [AW-1:0]   ALU_WA,
   input  logic [DW-1:0]   ALU_WD,
   input  logic            LD_REQ,
   input  logic [AW-1:0]   LD_WA,
   input  logic [DW-1:0]   LD_WD,
   output logic            LD_ACK,
   input  logic            SC_REQ,
   input  logic [AW-1:0]   SC_WA,
   input  logic [DW-1:0]   SC_WD,
   output logic            SC_ACK,
   output logic [DW-1:0]   RB_15_0,
   output logic [NREG-1:0] WR_15_0,
   output logic            BUSY
);

   // LD/SC handshake: an entry is taken on a rising edge with REQ && ACK.
   // ACK is simply "queue not full"; it ignores REQ and any same-edge pop.

   wrEntryT         ldHead;
   wrEntryT         scHead;
   logic            ldFull;
   logic            ldEmpty;
   logic            scFull;
   logic            scEmpty;
   logic            ldPop;
   logic            scPop;
   portSelT         grant;
   wrEntryT         grantEntry;
   portSelT         rrPtr;
   logic [NREG-1:0] wrReg;
   logic [DW-1:0]   rbReg;

   cga_wrf_wq2 #(.DEPTH(QDEPTH)) ldQueue (
      .clk      (ALUCLK),
      .rstN     (RESET_N),
      .push     (LD_REQ),
      .pushData ('{wa: LD_WA, wd: LD_WD}),
      .pop      (ldPop),
      .head     (ldHead),
      .full     (ldFull),
      .empty    (ldEmpty)
   );

   cga_wrf_wq2 #(.DEPTH(QDEPTH)) scQueue (
      .clk      (ALUCLK),
      .rstN     (RESET_N),
      .push     (SC_REQ),
      .pushData ('{wa: SC_WA, wd: SC_WD}),
      .pop      (scPop),
      .head     (scHead),
      .full     (scFull),
      .empty    (scEmpty)
   );

   // Arbitration sees only pre-edge queue state, so a fresh entry waits a cycle.
   always_comb begin
      grant      = PORT_NONE;
      grantEntry = '0;
      if (ALU_WE) begin
         grant      = PORT_ALU;
         grantEntry = '{wa: ALU_WA, wd: ALU_WD};
      end else if (!ldEmpty && (scEmpty || rrPtr == PORT_LD)) begin
         grant      = PORT_LD;
         grantEntry = ldHead;
      end else if (!scEmpty) begin
         grant      = PORT_SC;
         grantEntry = scHead;
      end
   end

   assign ldPop = (grant == PORT_LD);
   assign scPop = (grant == PORT_SC);

   always_ff @(posedge ALUCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         wrReg <= '0;
         rbReg <= '0;
         rrPtr <= PORT_LD;
      end else begin
         if (grant != PORT_NONE) begin
            wrReg <= oneHot(grantEntry.wa);
            rbReg <= grantEntry.wd;
         end else begin
            wrReg <= '0;
         end
         if (grant == PORT_LD)      rrPtr <= PORT_SC;
         else if (grant == PORT_SC) rrPtr <= PORT_LD;
      end
   end

   assign WR_15_0 = wrReg;
   assign RB_15_0 = rbReg;
   assign LD_ACK  = !ldFull;
   assign SC_ACK  = !scFull;
   // Empty flags come straight from the queue count flops.
   assign BUSY    = !(ldEmpty && scEmpty);

endmodule

// File: tb/tb_cga_wrf_write_sched.sv
// Directed and randomized bench for the register-file write scheduler,
// scored against a queue-based model of the port rules.
module tb_cga_wrf_write_sched;
   import cga_wrf_pkg::*;

   // ---------------- clock / reset ----------------
   logic ALUCLK  = 1'b0;
   logic RESET_N = 1'b0;
   always #5 ALUCLK = ~ALUCLK;

   logic            ALU_WE = 1'b0;
   logic [AW-1:0]   ALU_WA = '0;
   logic [DW-1:0]   ALU_WD = '0;
   logic            LD_REQ = 1'b0;
   logic [AW-1:0]   LD_WA  = '0;
   logic [DW-1:0]   LD_WD  = '0;
   logic            LD_ACK;
   logic            SC_REQ = 1'b0;
   logic [AW-1:0]   SC_WA  = '0;
   logic [DW-1:0]   SC_WD  = '0;
   logic            SC_ACK;
   logic [DW-1:0]   RB_15_0;
   logic [NREG-1:0] WR_15_0;
   logic            BUSY;

   cga_wrf_write_sched dut (
      .ALUCLK  (ALUCLK),
      .RESET_N (RESET_N),
      .ALU_WE  (ALU_WE),
      .ALU_WA  (ALU_WA),
      .ALU_WD  (ALU_WD),
      .LD_REQ  (LD_REQ),
      .LD_WA   (LD_WA),
      .LD_WD   (LD_WD),
      .LD_ACK  (LD_ACK),
      .SC_REQ  (SC_REQ),
      .SC_WA   (SC_WA),
      .SC_WD   (SC_WD),
      .SC_ACK  (SC_ACK),
      .RB_15_0 (RB_15_0),
      .WR_15_0 (WR_15_0),
      .BUSY    (BUSY)
   );

   // Register file fed by the DUT bus, so final register contents can be checked.
   logic [DW-1:0] reg_file [NREG];
   initial for (int n = 0; n < NREG; n++) reg_file[n] = '0;
   always @(posedge ALUCLK) begin
      for (int n = 0; n < NREG; n++)
         if (WR_15_0[n]) reg_file[n] <= RB_15_0;
   end

   // ---------------- scoreboard / model ----------------
   logic [AW+DW-1:0] ld_q[$];
   logic [AW+DW-1:0] sc_q[$];
   bit               rr_ld = 1'b1;
   logic [15:0]      exp_wr = '0;
   logic [15:0]      exp_rb = '0;
   int               vectors = 0;
   int               miscompares = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      if (obs !== expv) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
      end
   endtask

   task automatic model_reset();
      ld_q.delete();
      sc_q.delete();
      rr_ld  = 1'b1;
      exp_wr = '0;
      exp_rb = '0;
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      RESET_N = 1'b0;
      ALU_WE  = 1'b0;
      LD_REQ  = 1'b0;
      SC_REQ  = 1'b0;
      #1;
      check("rst_wr", 32'(WR_15_0), 32'h0);
      check("rst_rb", 32'(RB_15_0), 32'h0);
      check("rst_ld_ack", 32'(LD_ACK), 32'h1);
      check("rst_sc_ack", 32'(SC_ACK), 32'h1);
      check("rst_busy", 32'(BUSY), 32'h0);
      @(posedge ALUCLK);
      #1;
      RESET_N = 1'b1;
      model_reset();
   endtask

   // Apply one edge with the current inputs, advance the model, compare outputs.
   task automatic step();
      logic [AW+DW-1:0] g;
      bit granted;
      bit ld_can;
      bit sc_can;
      ld_can  = ld_q.size() < QDEPTH;
      sc_can  = sc_q.size() < QDEPTH;
      granted = 1'b0;
      g       = '0;
      if (ALU_WE) begin
         g = {ALU_WA, ALU_WD};
         granted = 1'b1;
      end else if (ld_q.size() != 0 && (sc_q.size() == 0 || rr_ld)) begin
         g = ld_q.pop_front();
         granted = 1'b1;
         rr_ld = 1'b0;
      end else if (sc_q.size() != 0) begin
         g = sc_q.pop_front();
         granted = 1'b1;
         rr_ld = 1'b1;
      end
      if (LD_REQ && ld_can) ld_q.push_back({LD_WA, LD_WD});
      if (SC_REQ && sc_can) sc_q.push_back({SC_WA, SC_WD});
      exp_wr = granted ? (16'h0001 << g[AW+DW-1:DW]) : 16'h0000;
      if (granted) exp_rb = g[DW-1:0];
      @(posedge ALUCLK);
      #1;
      check("wr", 32'(WR_15_0), 32'(exp_wr));
      check("rb", 32'(RB_15_0), 32'(exp_rb));
      check("ld_ack", 32'(LD_ACK), 32'(ld_q.size() < QDEPTH));
      check("sc_ack", 32'(SC_ACK), 32'(sc_q.size() < QDEPTH));
      check("busy", 32'(BUSY), 32'(ld_q.size() != 0 || sc_q.size() != 0));
   endtask

   task automatic idle_inputs();
      ALU_WE = 1'b0;
      LD_REQ = 1'b0;
      SC_REQ = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      do_reset();

      // Reset dropped mid-queue while a strobe is out.
      ALU_WE = 1'b1; ALU_WA = 4'd2; ALU_WD = 16'h1234;
      LD_REQ = 1'b1; LD_WA = 4'd5; LD_WD = 16'h5555;
      step();
      check("inflight_wr", 32'(WR_15_0), 32'h0004);
      do_reset();
      idle_inputs();
      step();
      check("post_rst_wr", 32'(WR_15_0), 32'h0);

      // ALU only.
      ALU_WE = 1'b1; ALU_WA = 4'd5; ALU_WD = 16'hA5A5;
      step();
      check("alu_wr", 32'(WR_15_0), 32'h0020);
      check("alu_rb", 32'(RB_15_0), 32'hA5A5);
      idle_inputs();
      step();
      check("alu_one_cycle", 32'(WR_15_0), 32'h0);

      // Queue fill under ALU starvation, then drain.
      do_reset();
      ALU_WE = 1'b1; ALU_WA = 4'd0; ALU_WD = 16'h0;
      LD_REQ = 1'b1; LD_WA = 4'd3; LD_WD = 16'h1111;
      step();
      LD_WA = 4'd4; LD_WD = 16'h2222;
      step();
      check("fill_ack", 32'(LD_ACK), 32'h0);
      LD_REQ = 1'b0;
      step();
      check("starve_busy", 32'(BUSY), 32'h1);
      ALU_WE = 1'b0;
      step();
      check("drain1_wr", 32'(WR_15_0), 32'h0008);
      step();
      check("drain2_wr", 32'(WR_15_0), 32'h0010);
      step();
      check("drain_busy", 32'(BUSY), 32'h0);

      // Round-robin between two full queues.
      do_reset();
      ALU_WE = 1'b1;
      LD_REQ = 1'b1; LD_WA = 4'd1; LD_WD = 16'hAAAA;
      SC_REQ = 1'b1; SC_WA = 4'd7; SC_WD = 16'hCCCC;
      step();
      LD_WA = 4'd2; LD_WD = 16'hBBBB;
      SC_WA = 4'd8; SC_WD = 16'hDDDD;
      step();
      idle_inputs();
      step();
      check("rr1", 32'(RB_15_0), 32'hAAAA);
      step();
      check("rr2", 32'(RB_15_0), 32'hCCCC);
      step();
      check("rr3", 32'(RB_15_0), 32'hBBBB);
      step();
      check("rr4", 32'(RB_15_0), 32'hDDDD);

      // Collision: ALU and queued load target register 9.
      do_reset();
      LD_REQ = 1'b1; LD_WA = 4'd9; LD_WD = 16'h0001;
      step();
      LD_REQ = 1'b0;
      ALU_WE = 1'b1; ALU_WA = 4'd9; ALU_WD = 16'hFFFF;
      step();
      check("coll_alu", 32'(RB_15_0), 32'hFFFF);
      idle_inputs();
      step();
      check("coll_ld", 32'(RB_15_0), 32'h0001);
      step();
      check("coll_reg9", 32'(reg_file[9]), 32'h0001);

      // Randomized traffic, with one reset part way through.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if (i == 200) do_reset();
         ALU_WE = ($urandom_range(0, 2) == 0);
         ALU_WA = AW'($urandom_range(0, NREG - 1));
         ALU_WD = DW'($urandom);
         LD_REQ = 1'($urandom_range(0, 1));
         LD_WA  = AW'($urandom_range(0, NREG - 1));
         LD_WD  = DW'($urandom);
         SC_REQ = 1'($urandom_range(0, 1));
         SC_WA  = AW'($urandom_range(0, NREG - 1));
         SC_WD  = DW'($urandom);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
